// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 serial receiver with centre-of-bit sampling.
// The baud divisor is chosen from a fixed eight-entry table at start-bit detection and held for
// the whole frame. Good frames update Rx_Byte with a one-cycle Rx_Done strobe; a low stop bit
// gives a one-cycle Frame_Error strobe and the receiver then waits for the line to go idle.

module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] baud_rate_select,
    input  logic       Rx_Serial,
    output logic [7:0] Rx_Byte,
    output logic       Rx_Done,
    output logic       Frame_Error,
    output logic       Rx_Active
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StStop  = 3'd3;
    localparam logic [2:0] StBreak = 3'd4;

    logic        rx_meta;
    logic        rx_sync;

    logic [2:0]  state_q, state_d;
    logic [10:0] div_q, div_d;
    logic [10:0] clk_count_q, clk_count_d;
    logic [2:0]  bit_index_q, bit_index_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_done_q, rx_done_d;
    logic        frame_error_q, frame_error_d;

    logic [10:0] div_sel;
    logic [10:0] half;
    logic        half_hit;
    logic        bit_hit;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx_Serial;
            rx_sync <= rx_meta;
        end
    end

    // Baud divisor table, clocks per bit.
    always_comb begin
        div_sel = 11'd1042;
        case (baud_rate_select)
            3'd0:    div_sel = 11'd1042;
            3'd1:    div_sel = 11'd695;
            3'd2:    div_sel = 11'd521;
            3'd3:    div_sel = 11'd261;
            3'd4:    div_sel = 11'd174;
            3'd5:    div_sel = 11'd87;
            3'd6:    div_sel = 11'd79;
            default: div_sel = 11'd39;
        endcase
    end

    assign half     = div_q >> 1;
    assign half_hit = (clk_count_q == (half - 11'd1));
    assign bit_hit  = (clk_count_q == (div_q - 11'd1));

    // Next-state logic for the frame FSM, counters, shift register and strobes.
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        clk_count_d   = clk_count_q;
        bit_index_d   = bit_index_q;
        shift_d       = shift_q;
        rx_byte_d     = rx_byte_q;
        rx_done_d     = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            StIdle: begin
                clk_count_d = 11'd0;
                bit_index_d = 3'd0;
                if (!rx_sync) begin
                    div_d   = div_sel;
                    state_d = StStart;
                end
            end

            StStart: begin
                if (half_hit) begin
                    clk_count_d = 11'd0;
                    // Line back high at mid-start means a glitch: drop it silently.
                    state_d = rx_sync ? StIdle : StData;
                end else begin
                    clk_count_d = clk_count_q + 11'd1;
                end
            end

            StData: begin
                if (bit_hit) begin
                    clk_count_d          = 11'd0;
                    shift_d[bit_index_q] = rx_sync;
                    if (bit_index_q == 3'd7) begin
                        bit_index_d = 3'd0;
                        state_d     = StStop;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end else begin
                    clk_count_d = clk_count_q + 11'd1;
                end
            end

            StStop: begin
                if (bit_hit) begin
                    clk_count_d = 11'd0;
                    if (rx_sync) begin
                        rx_byte_d = shift_q;
                        rx_done_d = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = StBreak;
                    end
                end else begin
                    clk_count_d = clk_count_q + 11'd1;
                end
            end

            StBreak: begin
                // Wait out a held-low line so a break never starts a new frame.
                clk_count_d = 11'd0;
                if (rx_sync) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d     = StIdle;
                clk_count_d = 11'd0;
                bit_index_d = 3'd0;
            end
        endcase
    end

    // State registers; reset aborts any frame in progress without a strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            div_q         <= 11'd0;
            clk_count_q   <= 11'd0;
            bit_index_q   <= 3'd0;
            shift_q       <= 8'd0;
            rx_byte_q     <= 8'd0;
            rx_done_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            clk_count_q   <= clk_count_d;
            bit_index_q   <= bit_index_d;
            shift_q       <= shift_d;
            rx_byte_q     <= rx_byte_d;
            rx_done_q     <= rx_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign Rx_Byte     = rx_byte_q;
    assign Rx_Done     = rx_done_q;
    assign Frame_Error = frame_error_q;
    assign Rx_Active   = (state_q == StStart) || (state_q == StData) || (state_q == StStop);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios for uart_rx with a bit-banged serial source.

module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] baud_rate_select = 3'd7;
    logic       Rx_Serial = 1'b1;
    logic [7:0] Rx_Byte;
    logic       Rx_Done;
    logic       Frame_Error;
    logic       Rx_Active;

    int total = 0;
    int bad   = 0;

    int cyc       = 0;
    int done_cnt  = 0;
    int fe_cnt    = 0;
    int act_cnt   = 0;
    int both_cnt  = 0;
    int done_cyc  = 0;
    int fe_cyc    = 0;
    logic [7:0] b0 = 8'h00;
    logic [7:0] b1 = 8'h00;
    logic [7:0] b2 = 8'h00;

    uart_rx dut (
        .clk              (clk),
        .rst              (rst),
        .baud_rate_select (baud_rate_select),
        .Rx_Serial        (Rx_Serial),
        .Rx_Byte          (Rx_Byte),
        .Rx_Done          (Rx_Done),
        .Frame_Error      (Frame_Error),
        .Rx_Active        (Rx_Active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe and activity monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (Rx_Done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            b0 <= Rx_Byte;
            b1 <= b0;
            b2 <= b1;
        end
        if (Frame_Error) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
        if (Rx_Active) act_cnt <= act_cnt + 1;
        if (Rx_Done && Frame_Error) both_cnt <= both_cnt + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8-N-1 frame; optionally changes the select during data bit 3.
    task automatic send_frame(input logic [7:0] b, input int div, input logic stop_bit,
                              input int chg_sel, output int st);
        st = cyc;
        Rx_Serial = 1'b0;
        wait_cyc(div);
        for (int k = 0; k < 8; k++) begin
            Rx_Serial = b[k];
            if (k == 3 && chg_sel >= 0) baud_rate_select = chg_sel[2:0];
            wait_cyc(div);
        end
        Rx_Serial = stop_bit;
        wait_cyc(div);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        total++;
        if (Rx_Byte !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h want=00", Rx_Byte); end
        total++;
        if ({Rx_Done, Frame_Error, Rx_Active} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {Rx_Done, Frame_Error, Rx_Active});
        end
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_good_slow;
        int st, d0, f0;
        d0 = done_cnt; f0 = fe_cnt;
        baud_rate_select = 3'd7;
        send_frame(8'h55, 39, 1'b1, -1, st);
        wait_cyc(5);
        total++;
        if (done_cnt - d0 !== 1) begin bad++; $display("FAIL slow_done_count got=%0d want=1", done_cnt - d0); end
        total++;
        if (b0 !== 8'h55) begin bad++; $display("FAIL slow_byte got=%h want=55", b0); end
        total++;
        if (Rx_Byte !== 8'h55) begin bad++; $display("FAIL slow_rx_byte got=%h want=55", Rx_Byte); end
        total++;
        if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL slow_fe got=%0d want=0", fe_cnt - f0); end
        total++;
        if (done_cyc - st !== 373) begin bad++; $display("FAIL slow_timing got=%0d want=373", done_cyc - st); end
    endtask

    task automatic test_good_fast;
        int st, d0;
        d0 = done_cnt;
        baud_rate_select = 3'd0;
        send_frame(8'hA3, 1042, 1'b1, -1, st);
        wait_cyc(5);
        total++;
        if (done_cnt - d0 !== 1) begin bad++; $display("FAIL fast_done_count got=%0d want=1", done_cnt - d0); end
        total++;
        if (Rx_Byte !== 8'hA3) begin bad++; $display("FAIL fast_byte got=%h want=a3", Rx_Byte); end
        total++;
        if (done_cyc - st !== 9902) begin bad++; $display("FAIL fast_timing got=%0d want=9902", done_cyc - st); end
    endtask

    task automatic test_glitch;
        int d0, f0, a0;
        d0 = done_cnt; f0 = fe_cnt; a0 = act_cnt;
        baud_rate_select = 3'd7;
        Rx_Serial = 1'b0;
        wait_cyc(10);
        Rx_Serial = 1'b1;
        wait_cyc(40);
        total++;
        if (act_cnt - a0 !== 19) begin bad++; $display("FAIL glitch_active_cycles got=%0d want=19", act_cnt - a0); end
        total++;
        if ((done_cnt - d0) + (fe_cnt - f0) !== 0) begin
            bad++; $display("FAIL glitch_strobes got=%0d want=0", (done_cnt - d0) + (fe_cnt - f0));
        end
        total++;
        if (Rx_Active !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b want=0", Rx_Active); end
    endtask

    task automatic test_frame_error;
        int st, d0, f0, a0;
        d0 = done_cnt; f0 = fe_cnt;
        baud_rate_select = 3'd7;
        send_frame(8'h0F, 39, 1'b0, -1, st);
        a0 = act_cnt;
        wait_cyc(2000);
        total++;
        if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL fe_count got=%0d want=1", fe_cnt - f0); end
        total++;
        if (fe_cyc - st !== 373) begin bad++; $display("FAIL fe_timing got=%0d want=373", fe_cyc - st); end
        total++;
        if (done_cnt - d0 !== 0) begin bad++; $display("FAIL fe_no_done got=%0d want=0", done_cnt - d0); end
        total++;
        if (Rx_Byte !== 8'hA3) begin bad++; $display("FAIL fe_byte_kept got=%h want=a3", Rx_Byte); end
        total++;
        if (act_cnt - a0 !== 0) begin bad++; $display("FAIL break_no_start got=%0d want=0", act_cnt - a0); end
        Rx_Serial = 1'b1;
        wait_cyc(20);
        send_frame(8'h3C, 39, 1'b1, -1, st);
        wait_cyc(5);
        total++;
        if (done_cnt - d0 !== 1 || Rx_Byte !== 8'h3C) begin
            bad++; $display("FAIL after_break got=%0d/%h want=1/3c", done_cnt - d0, Rx_Byte);
        end
    endtask

    task automatic test_reset_mid_frame;
        int st, d0, f0;
        d0 = done_cnt; f0 = fe_cnt;
        baud_rate_select = 3'd7;
        Rx_Serial = 1'b0;
        wait_cyc(39);
        Rx_Serial = 1'b1;
        wait_cyc(4 * 39 + 10);
        total++;
        if (Rx_Active !== 1'b1) begin bad++; $display("FAIL mid_active got=%b want=1", Rx_Active); end
        rst = 1'b0;
        #1;
        total++;
        if ({Rx_Byte, Rx_Done, Frame_Error, Rx_Active} !== 11'd0) begin
            bad++; $display("FAIL mid_reset_outputs got=%h/%b%b%b want=00/000",
                            Rx_Byte, Rx_Done, Frame_Error, Rx_Active);
        end
        wait_cyc(5);
        rst = 1'b1;
        wait_cyc(400);
        total++;
        if ((done_cnt - d0) + (fe_cnt - f0) !== 0) begin
            bad++; $display("FAIL mid_no_strobe got=%0d want=0", (done_cnt - d0) + (fe_cnt - f0));
        end
        send_frame(8'h81, 39, 1'b1, -1, st);
        wait_cyc(5);
        total++;
        if (done_cnt - d0 !== 1 || Rx_Byte !== 8'h81) begin
            bad++; $display("FAIL mid_next_frame got=%0d/%h want=1/81", done_cnt - d0, Rx_Byte);
        end
    endtask

    task automatic test_back_to_back;
        int st, d0, f0;
        d0 = done_cnt; f0 = fe_cnt;
        baud_rate_select = 3'd7;
        send_frame(8'h00, 39, 1'b1, -1, st);
        send_frame(8'hFF, 39, 1'b1, 3, st);
        baud_rate_select = 3'd7;
        send_frame(8'h5A, 39, 1'b1, -1, st);
        wait_cyc(5);
        total++;
        if (done_cnt - d0 !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", done_cnt - d0); end
        total++;
        if ({b2, b1, b0} !== 24'h00FF5A) begin
            bad++; $display("FAIL b2b_bytes got=%h want=00ff5a", {b2, b1, b0});
        end
        total++;
        if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL b2b_fe got=%0d want=0", fe_cnt - f0); end
        total++;
        if (both_cnt !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", both_cnt); end
    endtask

    initial begin
        #2;
        test_reset();
        test_good_slow();
        test_good_fast();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
